// File: rtl/tile_power_pkg.sv
// Shared types and helpers for the tile power governor: FSM states, widths,
// level-to-frequency mapping and a saturating counter increment.
package tile_power_pkg;

  localparam int POWER_W = 17;
  localparam int LEVEL_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_DECIDE,
    ST_REQUEST,
    ST_SETTLE
  } gov_state_e;

  function automatic logic [15:0] level_to_mhz(input logic [LEVEL_W-1:0] level,
                                               input int fmin, input int fstep);
    return 16'(fmin + int'(level) * fstep);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/tile_power_governor_averager.sv
// Fixed-window power averager: sums dynamic+leakage over 2^WINDOW_LOG2 samples,
// pulses done on the last sample and latches the truncated average.
module power_window_averager
  import tile_power_pkg::*;
#(
  parameter int WINDOW_LOG2 = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               acc_en,
  input  logic [15:0]        dynamic_power_mw,
  input  logic [15:0]        leakage_power_mw,
  output logic               done,
  output logic [POWER_W-1:0] avg_mw
);

  localparam int ACC_W = POWER_W + WINDOW_LOG2;

  logic [POWER_W-1:0]     sample;
  logic [ACC_W-1:0]       acc;
  logic [ACC_W-1:0]       acc_sum;
  logic [WINDOW_LOG2-1:0] cnt;

  assign sample  = {1'b0, dynamic_power_mw} + {1'b0, leakage_power_mw};
  assign acc_sum = acc + ACC_W'(sample);
  assign done    = acc_en && (cnt == '1);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      cnt    <= '0;
      avg_mw <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (acc_en) begin
      cnt <= cnt + 1'b1;
      if (done) begin
        acc    <= '0;
        avg_mw <= POWER_W'(acc_sum >> WINDOW_LOG2);
      end else begin
        acc <= acc_sum;
      end
    end
  end

endmodule

// File: rtl/tile_power_governor.sv
// Closed-loop DVFS governor for one tile. Optional macro
// TILE_GOV_EMERGENCY_THROTTLE_EN adds a single-sample drop-to-level-0 path.
//   state      | meaning
//   ST_IDLE    | governor disabled, holding current level
//   ST_SAMPLE  | accumulating one averaging window
//   ST_DECIDE  | compare window average with budget and hysteresis band
//   ST_REQUEST | new frequency offered, waiting for freq_req_ready
//   ST_SETTLE  | ignoring power while the new frequency settles
module tile_power_governor
  import tile_power_pkg::*;
#(
  parameter int WINDOW_LOG2   = 4,
  parameter int NUM_LEVELS    = 8,
  parameter int FMIN_MHZ      = 200,
  parameter int FSTEP_MHZ     = 100,
  parameter int INIT_LEVEL    = 7,
  parameter int HYST_MW       = 50,
  parameter int SETTLE_CYCLES = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [15:0]        power_budget_mw,
  input  logic [15:0]        dynamic_power_mw,
  input  logic [15:0]        leakage_power_mw,
  output logic               freq_req_valid,
  input  logic               freq_req_ready,
  output logic [15:0]        freq_req_mhz,
  output logic [15:0]        current_freq_mhz,
  output logic [LEVEL_W-1:0] current_level,
  output logic [POWER_W-1:0] avg_power_mw,
  output logic               throttled,
  output logic [15:0]        over_budget_count
);

  localparam int                 SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [LEVEL_W-1:0] INIT_LVL = LEVEL_W'(INIT_LEVEL);
  localparam logic [LEVEL_W-1:0] MAX_LVL  = LEVEL_W'(NUM_LEVELS - 1);

  gov_state_e          state, state_nxt;
  logic [LEVEL_W-1:0]  level, level_nxt, target, target_nxt;
  logic [SETTLE_W-1:0] settle_cnt, settle_nxt;
  logic [15:0]         obc, obc_nxt;
  logic                win_clear, win_acc, win_done;
  logic                emergency, over_budget, under_band;

  power_window_averager #(.WINDOW_LOG2(WINDOW_LOG2)) u_avg (
    .clk              (clk),
    .reset            (reset),
    .clear            (win_clear),
    .acc_en           (win_acc),
    .dynamic_power_mw (dynamic_power_mw),
    .leakage_power_mw (leakage_power_mw),
    .done             (win_done),
    .avg_mw           (avg_power_mw)
  );

`ifdef TILE_GOV_EMERGENCY_THROTTLE_EN
  logic [POWER_W-1:0] spike;
  assign spike     = {1'b0, dynamic_power_mw} + {1'b0, leakage_power_mw};
  assign emergency = ((state == ST_SAMPLE) || (state == ST_SETTLE)) &&
                     (spike > {power_budget_mw, 1'b0});
`else
  assign emergency = 1'b0;
`endif

  // Signed band: a budget below HYST_MW makes the threshold negative, so no step-up.
  assign over_budget = avg_power_mw > {1'b0, power_budget_mw};
  assign under_band  = int'(avg_power_mw) < (int'(power_budget_mw) - HYST_MW);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      level      <= INIT_LVL;
      target     <= INIT_LVL;
      settle_cnt <= '0;
      obc        <= '0;
    end else begin
      state      <= state_nxt;
      level      <= level_nxt;
      target     <= target_nxt;
      settle_cnt <= settle_nxt;
      obc        <= obc_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    level_nxt  = level;
    target_nxt = target;
    settle_nxt = settle_cnt;
    obc_nxt    = obc;
    win_clear  = (state != ST_SAMPLE);
    win_acc    = (state == ST_SAMPLE) && enable;
    case (state)
      ST_IDLE: if (enable) state_nxt = ST_SAMPLE;
      ST_SAMPLE, ST_SETTLE: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
        end else if (emergency) begin
          win_clear = 1'b1;
          win_acc   = 1'b0;
          obc_nxt   = sat_inc16(obc);
          if (level != '0) begin
            target_nxt = '0;
            state_nxt  = ST_REQUEST;
          end else begin
            state_nxt = ST_SAMPLE;
          end
        end else if (state == ST_SAMPLE) begin
          if (win_done) state_nxt = ST_DECIDE;
        end else if (settle_cnt == '0) begin
          state_nxt = ST_SAMPLE;
        end else begin
          settle_nxt = settle_cnt - 1'b1;
        end
      end
      ST_DECIDE: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
        end else if (over_budget) begin
          obc_nxt = sat_inc16(obc);
          if (level != '0) begin
            target_nxt = level - 1'b1;
            state_nxt  = ST_REQUEST;
          end else begin
            state_nxt = ST_SAMPLE;
          end
        end else if (under_band && (level < MAX_LVL)) begin
          target_nxt = level + 1'b1;
          state_nxt  = ST_REQUEST;
        end else begin
          state_nxt = ST_SAMPLE;
        end
      end
      // An offered request is never withdrawn; enable only matters after acceptance.
      ST_REQUEST: begin
        if (freq_req_ready) begin
          level_nxt  = target;
          settle_nxt = SETTLE_W'(SETTLE_CYCLES);
          state_nxt  = enable ? ST_SETTLE : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign freq_req_valid    = (state == ST_REQUEST);
  assign current_freq_mhz  = level_to_mhz(level, FMIN_MHZ, FSTEP_MHZ);
  assign freq_req_mhz      = freq_req_valid ? level_to_mhz(target, FMIN_MHZ, FSTEP_MHZ)
                                            : current_freq_mhz;
  assign current_level     = level;
  assign throttled         = (level < INIT_LVL);
  assign over_budget_count = obc;

endmodule

// File: tb/tb_tile_power_governor.sv
// Self-checking bench for tile_power_governor: randomized power windows checked
// against a window-level reference model of the budget/hysteresis rules.
module tb_tile_power_governor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        freq_req_ready = 1'b0;
  logic [15:0] power_budget_mw = '0;
  logic [15:0] dynamic_power_mw = '0;
  logic [15:0] leakage_power_mw = '0;
  logic        freq_req_valid;
  logic [15:0] freq_req_mhz;
  logic [15:0] current_freq_mhz;
  logic [3:0]  current_level;
  logic [16:0] avg_power_mw;
  logic        throttled;
  logic [15:0] over_budget_count;

  int errors = 0;
  int checks = 0;
  int m_level = 7;
  int m_obc = 0;

  always #5 clk = ~clk;

  tile_power_governor dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .power_budget_mw   (power_budget_mw),
    .dynamic_power_mw  (dynamic_power_mw),
    .leakage_power_mw  (leakage_power_mw),
    .freq_req_valid    (freq_req_valid),
    .freq_req_ready    (freq_req_ready),
    .freq_req_mhz      (freq_req_mhz),
    .current_freq_mhz  (current_freq_mhz),
    .current_level     (current_level),
    .avg_power_mw      (avg_power_mw),
    .throttled         (throttled),
    .over_budget_count (over_budget_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int mhz(input int lvl);
    return 200 + 100 * lvl;
  endfunction

  task automatic model_decide(input int avg, input int budget, output int nl);
    nl = m_level;
    if (avg > budget) begin
      if (m_obc < 65535) m_obc++;
      if (m_level > 0) nl = m_level - 1;
    end else if ((avg < budget - 50) && (m_level < 7)) begin
      nl = m_level + 1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    freq_req_ready = 1'b0;
    dynamic_power_mw = '0;
    leakage_power_mw = '0;
    tick();
    tick();
    reset = 1'b0;
    m_level = 7;
    m_obc = 0;
  endtask

  // Drives one full window; the budget seen mid-window is junk, the real one is set for DECIDE.
  task automatic drive_window(input int budget, input int dmin, input int dmax,
                              input int lmin, input int lmax, input string tag,
                              output int avg);
    int sum, d, l, junk;
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      d = int'($urandom_range(dmax, dmin));
      l = int'($urandom_range(lmax, lmin));
      sum += d + l;
      junk = budget + int'($urandom_range(1000, 0));
      if (junk > 65535) junk = 65535;
      dynamic_power_mw = 16'(d);
      leakage_power_mw = 16'(l);
      power_budget_mw = 16'(junk);
      freq_req_ready = 1'($urandom_range(1, 0));
      tick();
    end
    power_budget_mw = 16'(budget);
    dynamic_power_mw = '0;
    leakage_power_mw = '0;
    avg = sum >> 4;
    checks++;
    if (avg_power_mw !== 17'(avg)) begin
      errors++;
      $display("FAIL %s avg_power_mw got %0d expected %0d", tag, avg_power_mw, avg);
    end
  endtask

  task automatic decide_and_apply(input int avg, input int budget, input string tag);
    int nl, hi;
    bit req;
    model_decide(avg, budget, nl);
    req = (nl != m_level);
    freq_req_ready = 1'b1;
    tick();
    checks++;
    if (freq_req_valid !== req) begin
      errors++;
      $display("FAIL %s freq_req_valid got %0b expected %0b", tag, freq_req_valid, req);
    end
    checks++;
    if (over_budget_count !== 16'(m_obc)) begin
      errors++;
      $display("FAIL %s over_budget_count got %0d expected %0d", tag, over_budget_count, m_obc);
    end
    if (req) begin
      checks++;
      if (freq_req_mhz !== 16'(mhz(nl))) begin
        errors++;
        $display("FAIL %s freq_req_mhz got %0d expected %0d", tag, freq_req_mhz, mhz(nl));
      end
      tick();
      m_level = nl;
      checks++;
      if (current_level !== 4'(m_level) || current_freq_mhz !== 16'(mhz(m_level)) ||
          freq_req_valid !== 1'b0 || throttled !== (m_level < 7)) begin
        errors++;
        $display("FAIL %s apply level=%0d freq=%0d valid=%0b thr=%0b expected level=%0d freq=%0d valid=0",
                 tag, current_level, current_freq_mhz, freq_req_valid, throttled, m_level, mhz(m_level));
      end
      hi = 0;
      for (int i = 0; i < 33; i++) begin
        freq_req_ready = 1'($urandom_range(1, 0));
        tick();
        if (freq_req_valid) hi++;
      end
      checks++;
      if (hi != 0) begin
        errors++;
        $display("FAIL %s settle valid cycles got %0d expected 0", tag, hi);
      end
    end
  endtask

  task automatic run_window(input int budget, input int dmin, input int dmax,
                            input int lmin, input int lmax, input string tag);
    int avg;
    drive_window(budget, dmin, dmax, lmin, lmax, tag, avg);
    decide_and_apply(avg, budget, tag);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (freq_req_valid !== 1'b0 || freq_req_mhz !== 16'd900 || current_freq_mhz !== 16'd900) begin
      errors++;
      $display("FAIL reset_freq valid=%0b req=%0d cur=%0d expected 0/900/900",
               freq_req_valid, freq_req_mhz, current_freq_mhz);
    end
    checks++;
    if (current_level !== 4'd7 || throttled !== 1'b0) begin
      errors++;
      $display("FAIL reset_level level=%0d thr=%0b expected 7/0", current_level, throttled);
    end
    checks++;
    if (avg_power_mw !== 17'd0 || over_budget_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_counts avg=%0d obc=%0d expected 0/0", avg_power_mw, over_budget_count);
    end
  endtask

  task automatic test_hold_at_max();
    enable = 1'b1;
    tick();
    run_window(1000, 600, 600, 100, 100, "hold_exact");
    run_window(1000, 0, 800, 0, 100, "hold_rand_a");
    run_window(1000, 0, 800, 0, 100, "hold_rand_b");
  endtask

  task automatic test_step_down();
    for (int i = 0; i < 8; i++) run_window(500, 500, 500, 100, 100, "step_down");
    checks++;
    if (current_level !== 4'd0 || current_freq_mhz !== 16'd200 || throttled !== 1'b1) begin
      errors++;
      $display("FAIL step_down_floor level=%0d freq=%0d thr=%0b expected 0/200/1",
               current_level, current_freq_mhz, throttled);
    end
  endtask

  task automatic test_hysteresis();
    for (int i = 0; i < 3; i++) run_window(1000, 400, 400, 100, 100, "hyst_climb");
    run_window(1000, 870, 870, 100, 100, "hyst_970");
    run_window(1000, 850, 850, 100, 100, "hyst_950");
    run_window(1000, 900, 900, 100, 100, "hyst_1000");
    run_window(1000, 840, 840, 100, 100, "hyst_940");
    run_window(1000, 901, 901, 100, 100, "hyst_1001");
    run_window(1000, 950, 1000, 0, 0, "hyst_band_rand");
  endtask

  task automatic test_stall_enable();
    int avg, nl, bad, hi;
    drive_window(500, 600, 600, 0, 0, "stall", avg);
    model_decide(avg, 500, nl);
    freq_req_ready = 1'b0;
    tick();
    checks++;
    if (freq_req_valid !== 1'b1 || freq_req_mhz !== 16'(mhz(nl))) begin
      errors++;
      $display("FAIL stall_req valid=%0b mhz=%0d expected 1/%0d", freq_req_valid, freq_req_mhz, mhz(nl));
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) enable = 1'b0;
      dynamic_power_mw = 16'($urandom_range(2000, 0));
      tick();
      if (freq_req_valid !== 1'b1 || freq_req_mhz !== 16'(mhz(nl)) || current_level !== 4'(m_level)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_stable unstable cycles got %0d expected 0", bad);
    end
    freq_req_ready = 1'b1;
    tick();
    m_level = nl;
    checks++;
    if (current_level !== 4'(m_level) || freq_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_accept level=%0d valid=%0b expected %0d/0", current_level, freq_req_valid, m_level);
    end
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      dynamic_power_mw = 16'($urandom_range(3000, 0));
      freq_req_ready = 1'($urandom_range(1, 0));
      tick();
      if (freq_req_valid) hi++;
    end
    checks++;
    if (hi != 0 || current_level !== 4'(m_level) || avg_power_mw !== 17'(avg)) begin
      errors++;
      $display("FAIL idle_hold valid_cycles=%0d level=%0d avg=%0d expected 0/%0d/%0d",
               hi, current_level, avg_power_mw, m_level, avg);
    end
    dynamic_power_mw = '0;
    enable = 1'b1;
    tick();
    run_window(1000, 200, 200, 0, 0, "reenable");
  endtask

  task automatic test_max_sample();
    run_window(65535, 65535, 65535, 65535, 65535, "max_sample");
  endtask

  task automatic test_random();
    int budget;
    for (int i = 0; i < 6; i++) begin
      budget = 300 + int'($urandom_range(1200, 0));
      run_window(budget, 0, 2 * budget - 100, 0, 100, "random");
    end
  endtask

  task automatic test_reset_midreq();
    int avg, nl;
    do_reset();
    enable = 1'b1;
    tick();
    drive_window(300, 500, 500, 0, 0, "midreq", avg);
    model_decide(avg, 300, nl);
    freq_req_ready = 1'b0;
    tick();
    checks++;
    if (freq_req_valid !== 1'b1 || freq_req_mhz !== 16'(mhz(nl))) begin
      errors++;
      $display("FAIL midreq_pending valid=%0b mhz=%0d expected 1/%0d", freq_req_valid, freq_req_mhz, mhz(nl));
    end
    reset = 1'b1;
    enable = 1'b0;
    tick();
    checks++;
    if (freq_req_valid !== 1'b0 || current_freq_mhz !== 16'd900 ||
        over_budget_count !== 16'd0 || current_level !== 4'd7) begin
      errors++;
      $display("FAIL midreq_reset valid=%0b cur=%0d obc=%0d level=%0d expected 0/900/0/7",
               freq_req_valid, current_freq_mhz, over_budget_count, current_level);
    end
    reset = 1'b0;
    m_level = 7;
    m_obc = 0;
  endtask

  task automatic test_spike();
    int early;
    do_reset();
    enable = 1'b1;
    freq_req_ready = 1'b1;
    power_budget_mw = 16'd300;
    tick();
    early = 0;
    for (int i = 0; i < 6; i++) begin
      dynamic_power_mw = (i == 5) ? 16'd600 : 16'd100;
      leakage_power_mw = (i == 5) ? 16'd100 : 16'd0;
      tick();
      if (freq_req_valid) early++;
    end
    dynamic_power_mw = '0;
    leakage_power_mw = '0;
`ifdef TILE_GOV_EMERGENCY_THROTTLE_EN
    checks++;
    if (early != 1 || freq_req_valid !== 1'b1 || freq_req_mhz !== 16'd200 || over_budget_count !== 16'd1) begin
      errors++;
      $display("FAIL emergency valid_cycles=%0d valid=%0b mhz=%0d obc=%0d expected 1/1/200/1",
               early, freq_req_valid, freq_req_mhz, over_budget_count);
    end
    tick();
    checks++;
    if (current_level !== 4'd0 || current_freq_mhz !== 16'd200) begin
      errors++;
      $display("FAIL emergency_apply level=%0d freq=%0d expected 0/200", current_level, current_freq_mhz);
    end
`else
    checks++;
    if (early != 0 || over_budget_count !== 16'd0) begin
      errors++;
      $display("FAIL spike_ignored valid_cycles=%0d obc=%0d expected 0/0", early, over_budget_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_hold_at_max();
    test_step_down();
    test_hysteresis();
    test_stall_enable();
    test_max_sample();
    test_random();
    test_reset_midreq();
    test_spike();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
